pir_light_ctrl: RTL

PIR_LIGHT_CTRL -- requirements
Module: pir_light_ctrl

---
 rtl/pir_ctrl_pkg.sv | 21 ++
 rtl/pir_qualifier.sv | 50 +++++
 rtl/pir_light_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pir_ctrl_pkg.sv
// rtl/pir_ctrl_pkg.sv - shared state encodings, counter width and helpers for the PIR light controller
package pir_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_WARMUP  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ON      = 3'd2,
    ST_HOLD    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Largest of the three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pir_qualifier.sv
// rtl/pir_qualifier.sv - PIR synchroniser and consecutive-high motion qualifier
module pir_qualifier #(
  parameter int QUAL_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pirSensor,
  output logic motion_q
);

  localparam int QW = $clog2(QUAL_CYC + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          motion_d;

  // Two-stage synchroniser feeds the run-length counter; motion asserts on the
  // same edge the run reaches QUAL_CYC and drops on the first low sample.
  always_comb begin
    sync1_d  = pirSensor;
    sync2_d  = sync1_q;
    qcnt_d   = '0;
    motion_d = 1'b0;
    if (sync2_q) begin
      if (qcnt_q != QW'(QUAL_CYC)) begin
        qcnt_d = qcnt_q + QW'(1);
      end else begin
        qcnt_d = qcnt_q;
      end
      motion_d = (qcnt_d == QW'(QUAL_CYC));
    end
  end

  // Synchroniser, counter and motion flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      qcnt_q   <= '0;
      motion_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      qcnt_q   <= qcnt_d;
      motion_q <= motion_d;
    end
  end

endmodule

// File: rtl/pir_light_ctrl.sv
// rtl/pir_light_ctrl.sv - PIR-driven lamp controller with warm-up, hold and lockout phases
module pir_light_ctrl
  import pir_ctrl_pkg::*;
#(
  parameter int WARMUP_CYC  = 1000,
  parameter int QUAL_CYC    = 4,
  parameter int HOLD_CYC    = 50,
  parameter int LOCKOUT_CYC = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pirSensor,
  input  logic        force_on,
  input  logic        force_off,
  output logic        led,
  output logic [2:0]  state_o,
  output logic [15:0] motion_cnt
);

  localparam int TMAX = max3(WARMUP_CYC, HOLD_CYC, LOCKOUT_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             motion_q;

  pir_qualifier #(
    .QUAL_CYC (QUAL_CYC)
  ) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .pirSensor (pirSensor),
    .motion_q  (motion_q)
  );

  // Next-state, shared timer and activation counter; overrides only touch the lamp.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WARMUP: begin
        // Timer counts up from zero so reset can simply clear it.
        if (timer_q == TW'(WARMUP_CYC - 1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_IDLE: begin
        if (motion_q) begin
          state_d = ST_ON;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ON: begin
        if (!motion_q) begin
          state_d = ST_HOLD;
          timer_d = TW'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        // Retrigger takes priority over expiry.
        if (motion_q) begin
          state_d = ST_ON;
        end else if (timer_q == '0) begin
          state_d = ST_LOCKOUT;
          timer_d = TW'(LOCKOUT_CYC - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    led_d = (state_d == ST_ON) || (state_d == ST_HOLD);
    if (force_on) begin
      led_d = 1'b1;
    end
    if (force_off) begin
      led_d = 1'b0;
    end
  end

  // State, timer, counter and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WARMUP;
      timer_q <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign led        = led_q;
  assign state_o    = state_q;
  assign motion_cnt = cnt_q;

endmodule
